// File: rtl/ex_stage.sv
// ex_stage: execute stage of the 5-stage word-addressed pipeline.
//
// Takes the ID/EX latch, computes the ALU result, resolves branches and jumps, and registers
// the EX/MEM latch. ex_mem_cond/ex_mem_alu_out drive the fetch redirect. After a taken
// branch/jump the next BRANCH_SHADOW valid instructions are squashed into bubbles.
//
// Optional feature: define FS_MUL_EN to include the iterative shift-add multiplier
// (op 00 funct 18). Without it, MUL decodes as a NOP and ex_stall is tied low.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   id_ex_valid         ID/EX holds a real instruction
//   id_ex_npc/ir/a/b/imm ID/EX latch contents
//   ex_stall            hold IF and ID/EX this cycle (multiplier busy)
//   ex_mem_valid/cond/alu_out/b/ir/rd  registered EX/MEM latch
module ex_stage #(
  parameter int unsigned BRANCH_SHADOW = 2,
  parameter int unsigned MUL_CYCLES    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ex_valid,
  input  logic [31:0] id_ex_npc,
  input  logic [31:0] id_ex_ir,
  input  logic [31:0] id_ex_a,
  input  logic [31:0] id_ex_b,
  input  logic [31:0] id_ex_imm,
  output logic        ex_stall,
  output logic        ex_mem_valid,
  output logic        ex_mem_cond,
  output logic [31:0] ex_mem_alu_out,
  output logic [31:0] ex_mem_b,
  output logic [31:0] ex_mem_ir,
  output logic [4:0]  ex_mem_rd
);

  localparam logic [5:0] OpSpecial = 6'h00;
  localparam logic [5:0] OpJ       = 6'h02;
  localparam logic [5:0] OpBeq     = 6'h04;
  localparam logic [5:0] OpBne     = 6'h05;
  localparam logic [5:0] OpAddi    = 6'h08;
  localparam logic [5:0] OpLw      = 6'h23;
  localparam logic [5:0] OpSw      = 6'h2B;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;
  localparam logic [5:0] FnOr  = 6'h25;
  localparam logic [5:0] FnSlt = 6'h2A;

  logic [5:0] op;
  logic [5:0] funct;
  assign op    = id_ex_ir[31:26];
  assign funct = id_ex_ir[5:0];

  // Combinational decode of the instruction in ID/EX
  logic [31:0] alu_res;
  logic        cond_res;
  logic [4:0]  rd_res;

  always_comb begin
    alu_res  = '0;
    cond_res = 1'b0;
    rd_res   = '0;
    case (op)
      OpSpecial: begin
        rd_res = id_ex_ir[15:11];
        case (funct)
          FnAdd:   alu_res = id_ex_a + id_ex_b;
          FnSub:   alu_res = id_ex_a - id_ex_b;
          FnAnd:   alu_res = id_ex_a & id_ex_b;
          FnOr:    alu_res = id_ex_a | id_ex_b;
          FnSlt:   alu_res = {31'b0, ($signed(id_ex_a) < $signed(id_ex_b))};
          default: rd_res  = '0;
        endcase
      end
      OpAddi, OpLw: begin
        alu_res = id_ex_a + id_ex_imm;
        rd_res  = id_ex_ir[20:16];
      end
      OpSw:  alu_res = id_ex_a + id_ex_imm;
      OpBeq: begin
        alu_res  = id_ex_npc + id_ex_imm;
        cond_res = (id_ex_a == id_ex_b);
      end
      OpBne: begin
        alu_res  = id_ex_npc + id_ex_imm;
        cond_res = (id_ex_a != id_ex_b);
      end
      OpJ: begin
        alu_res  = {id_ex_npc[31:26], id_ex_ir[25:0]};
        cond_res = 1'b1;
      end
      default: ;
    endcase
  end

  // accept: EX is free to consume ID/EX this cycle
  logic accept;
  logic mul_start;
  logic shadow_active;
  logic [1:0] shadow_q, shadow_d;

  assign shadow_active = (shadow_q != 2'd0);

`ifdef FS_MUL_EN
  localparam int unsigned CntW = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;
  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StBusy = 1'b1;

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     acc_q, acc_d;
  logic [31:0]     mcand_q, mcand_d;
  logic [31:0]     mplier_q, mplier_d;
  logic [31:0]     mb_q, mir_q;
  logic [4:0]      mrd_q;
  logic            done_q, done_d;
  logic            is_mul;
  logic            mul_last;
  logic [31:0]     mul_sum;

  assign is_mul    = (op == OpSpecial) && (funct == 6'h18);
  // Upstream still holds the finished MUL in ID/EX for one cycle after completion
  // (ex_stall was high through the last step), so that cycle must not re-issue it.
  assign accept    = (state_q == StIdle) && !done_q;
  assign mul_start = accept && id_ex_valid && !shadow_active && is_mul;
  assign mul_last  = (state_q == StBusy) && (cnt_q == CntW'(MUL_CYCLES - 1));
  assign mul_sum   = acc_q + (mplier_q[0] ? mcand_q : 32'd0);
  assign ex_stall  = (state_q == StBusy) || mul_start;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    done_d   = 1'b0;
    if (mul_start) begin
      state_d  = StBusy;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = id_ex_a;
      mplier_d = id_ex_b;
    end else if (state_q == StBusy) begin
      acc_d    = mul_sum;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
      if (mul_last) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      mb_q     <= '0;
      mir_q    <= '0;
      mrd_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      done_q   <= done_d;
      if (mul_start) begin
        mb_q  <= id_ex_b;
        mir_q <= id_ex_ir;
        mrd_q <= id_ex_ir[15:11];
      end
    end
  end
`else
  assign accept    = 1'b1;
  assign mul_start = 1'b0;
  assign ex_stall  = 1'b0;
`endif

  // EX/MEM next state
  logic        valid_d, cond_d;
  logic [31:0] alu_d, b_d, ir_d;
  logic [4:0]  rd_d;

  always_comb begin
    valid_d  = 1'b0;
    cond_d   = 1'b0;
    rd_d     = '0;
    alu_d    = alu_res;
    b_d      = id_ex_b;
    ir_d     = id_ex_ir;
    shadow_d = shadow_q;
    if (accept && id_ex_valid) begin
      if (shadow_active) begin
        // Wrong-path instruction: bubble, never reloads the shadow or starts a MUL
        shadow_d = shadow_q - 2'd1;
      end else if (!mul_start) begin
        valid_d = 1'b1;
        cond_d  = cond_res;
        rd_d    = rd_res;
        if (cond_res) shadow_d = 2'(BRANCH_SHADOW);
      end
    end
`ifdef FS_MUL_EN
    if (mul_last) begin
      valid_d = 1'b1;
      alu_d   = mul_sum;
      b_d     = mb_q;
      ir_d    = mir_q;
      rd_d    = mrd_q;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_mem_valid   <= 1'b0;
      ex_mem_cond    <= 1'b0;
      ex_mem_alu_out <= '0;
      ex_mem_b       <= '0;
      ex_mem_ir      <= '0;
      ex_mem_rd      <= '0;
      shadow_q       <= '0;
    end else begin
      ex_mem_valid   <= valid_d;
      ex_mem_cond    <= cond_d;
      ex_mem_alu_out <= alu_d;
      ex_mem_b       <= b_d;
      ex_mem_ir      <= ir_d;
      ex_mem_rd      <= rd_d;
      shadow_q       <= shadow_d;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
module tb_ex_stage;

  localparam int unsigned BranchShadow = 2;
  localparam int unsigned MulCycles    = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_ex_valid;
  logic [31:0] id_ex_npc, id_ex_ir, id_ex_a, id_ex_b, id_ex_imm;
  logic        ex_stall, ex_mem_valid, ex_mem_cond;
  logic [31:0] ex_mem_alu_out, ex_mem_b, ex_mem_ir;
  logic [4:0]  ex_mem_rd;

  ex_stage #(
    .BRANCH_SHADOW(BranchShadow),
    .MUL_CYCLES   (MulCycles)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .id_ex_valid   (id_ex_valid),
    .id_ex_npc     (id_ex_npc),
    .id_ex_ir      (id_ex_ir),
    .id_ex_a       (id_ex_a),
    .id_ex_b       (id_ex_b),
    .id_ex_imm     (id_ex_imm),
    .ex_stall      (ex_stall),
    .ex_mem_valid  (ex_mem_valid),
    .ex_mem_cond   (ex_mem_cond),
    .ex_mem_alu_out(ex_mem_alu_out),
    .ex_mem_b      (ex_mem_b),
    .ex_mem_ir     (ex_mem_ir),
    .ex_mem_rd     (ex_mem_rd)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          m_shadow = 0;
  int          m_left   = 0;  // multiplier cycles still to run
  bit          m_done   = 0;  // finished MUL still sitting in ID/EX
  logic [31:0] m_prod, m_b, m_ir;
  logic [4:0]  m_rd;
  logic        last_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%h exp=%h", name, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs, rt,
                                        input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ir, a, b, npc);
    id_ex_valid = v;
    id_ex_ir    = ir;
    id_ex_a     = a;
    id_ex_b     = b;
    id_ex_npc   = npc;
    id_ex_imm   = {{16{ir[15]}}, ir[15:0]};
  endtask

  // Architectural meaning of one instruction
  task automatic ref_exec(output logic [31:0] alu, output logic cond, output logic [4:0] rd);
    logic [5:0] op, fn;
    op = id_ex_ir[31:26];
    fn = id_ex_ir[5:0];
    alu = 0; cond = 0; rd = 0;
    if (op == 6'h00) begin
      if (fn == 6'h20) begin alu = id_ex_a + id_ex_b; rd = id_ex_ir[15:11]; end
      if (fn == 6'h22) begin alu = id_ex_a - id_ex_b; rd = id_ex_ir[15:11]; end
      if (fn == 6'h24) begin alu = id_ex_a & id_ex_b; rd = id_ex_ir[15:11]; end
      if (fn == 6'h25) begin alu = id_ex_a | id_ex_b; rd = id_ex_ir[15:11]; end
      if (fn == 6'h2A) begin
        alu = (int'(id_ex_a) < int'(id_ex_b)) ? 32'd1 : 32'd0;
        rd  = id_ex_ir[15:11];
      end
    end else if (op == 6'h08 || op == 6'h23) begin
      alu = id_ex_a + id_ex_imm; rd = id_ex_ir[20:16];
    end else if (op == 6'h2B) begin
      alu = id_ex_a + id_ex_imm;
    end else if (op == 6'h04 || op == 6'h05) begin
      alu  = id_ex_npc + id_ex_imm;
      cond = (op == 6'h04) ? (id_ex_a == id_ex_b) : (id_ex_a != id_ex_b);
    end else if (op == 6'h02) begin
      alu  = {id_ex_npc[31:26], id_ex_ir[25:0]};
      cond = 1;
    end
  endtask

  // One clock: check stall against the model, advance the model, check EX/MEM after the edge
  task automatic cycle();
    logic        ev, ec, full, is_mul, mul_issue, exp_stall;
    logic [31:0] ea, eb, eir;
    logic [4:0]  erd;
    #1;
`ifdef FS_MUL_EN
    is_mul = (id_ex_ir[31:26] == 6'h00) && (id_ex_ir[5:0] == 6'h18);
`else
    is_mul = 1'b0;
`endif
    mul_issue = !reset && m_left == 0 && !m_done && id_ex_valid && m_shadow == 0 && is_mul;
    exp_stall = (m_left > 0) || mul_issue;
    if (!reset) chk("ex_stall", {31'b0, ex_stall}, {31'b0, exp_stall});
    last_stall = exp_stall;
    ev = 0; ec = 0; full = 0; ea = 0; eb = 0; eir = 0; erd = 0;
    if (reset) begin
      full = 1; m_shadow = 0; m_left = 0; m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        ev = 1; full = 1; ea = m_prod; eb = m_b; eir = m_ir; erd = m_rd; m_done = 1;
      end
    end else if (m_done) begin
      m_done = 0;
    end else if (id_ex_valid) begin
      if (m_shadow > 0) begin
        m_shadow--;
      end else if (mul_issue) begin
        m_left = MulCycles;
        m_prod = id_ex_a * id_ex_b;
        m_b    = id_ex_b;
        m_ir   = id_ex_ir;
        m_rd   = id_ex_ir[15:11];
      end else begin
        ref_exec(ea, ec, erd);
        ev = 1; full = 1; eb = id_ex_b; eir = id_ex_ir;
        if (ec) m_shadow = BranchShadow;
      end
    end
    @(posedge clk);
    #1;
    chk("valid", {31'b0, ex_mem_valid}, {31'b0, ev});
    chk("cond", {31'b0, ex_mem_cond}, {31'b0, ec});
    chk("rd", {27'b0, ex_mem_rd}, {27'b0, erd});
    if (full) begin
      chk("alu_out", ex_mem_alu_out, ea);
      chk("b", ex_mem_b, eb);
      chk("ir", ex_mem_ir, eir);
    end
  endtask

  task automatic rand_instr();
    logic [5:0]  fns [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [4:0]  rs, rt, rd;
    logic [15:0] imm;
    logic [31:0] a, b, ir;
    int          k;
    rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom); imm = 16'($urandom);
    a = $urandom; b = $urandom;
    if ($urandom_range(0, 3) == 0) begin a = $urandom_range(0, 3); b = $urandom_range(0, 3); end
    k = $urandom_range(0, 12);
    case (k)
      0, 1, 2, 3, 4: ir = rtype(fns[k], rs, rt, rd);
      5:  ir = itype(6'h08, rs, rt, imm);
      6:  ir = itype(6'h23, rs, rt, imm);
      7:  ir = itype(6'h2B, rs, rt, imm);
      8:  ir = itype(6'h04, rs, rt, imm);
      9:  ir = itype(6'h05, rs, rt, imm);
      10: ir = {6'h02, 26'($urandom)};
      11: ir = ($urandom_range(0, 7) == 0) ? rtype(6'h18, rs, rt, rd) : rtype(6'h20, rs, rt, rd);
      default: ir = $urandom;
    endcase
    if ((k == 8 || k == 9) && $urandom_range(0, 1) == 0) b = a;
    drive($urandom_range(0, 4) != 0, ir, a, b, $urandom);
  endtask

  int          n;
  logic [31:0] got_a;
  logic [4:0]  got_rd;

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    repeat (3) cycle();
    reset = 1'b0;

    // ADD 5+7 -> r3
    drive(1, rtype(6'h20, 1, 2, 3), 5, 7, 1);
    cycle();
    chk("add_valid", {31'b0, ex_mem_valid}, 1);
    chk("add_alu", ex_mem_alu_out, 12);
    chk("add_rd", {27'b0, ex_mem_rd}, 3);
    chk("add_cond", {31'b0, ex_mem_cond}, 0);

    drive(1, rtype(6'h22, 1, 2, 3), 0, 1, 2);
    cycle();
    chk("sub_wrap", ex_mem_alu_out, 32'hFFFF_FFFF);
    drive(1, rtype(6'h2A, 1, 2, 4), 32'hFFFF_FFFF, 1, 3);
    cycle();
    chk("slt_signed", ex_mem_alu_out, 1);
    drive(1, itype(6'h08, 1, 9, 16'h0001), 32'h7FFF_FFFF, 0, 4);
    cycle();
    chk("addi_wrap", ex_mem_alu_out, 32'h8000_0000);
    chk("addi_rd", {27'b0, ex_mem_rd}, 9);

    // Taken BEQ squashes the next two valid instructions
    drive(1, itype(6'h04, 1, 2, 16'hFFFC), 9, 9, 32'h10);
    cycle();
    chk("beq_cond", {31'b0, ex_mem_cond}, 1);
    chk("beq_target", ex_mem_alu_out, 32'h0000_000C);
    drive(1, rtype(6'h20, 1, 2, 3), 1, 1, 0);
    cycle();
    chk("sq1_valid", {31'b0, ex_mem_valid}, 0);
    cycle();
    chk("sq2_valid", {31'b0, ex_mem_valid}, 0);
    drive(1, rtype(6'h20, 1, 2, 3), 1, 2, 0);
    cycle();
    chk("post_sq_valid", {31'b0, ex_mem_valid}, 1);
    chk("post_sq_alu", ex_mem_alu_out, 3);
    drive(1, itype(6'h04, 1, 2, 16'hFFFC), 1, 2, 32'h10);
    cycle();
    chk("beq_nt_cond", {31'b0, ex_mem_cond}, 0);
    drive(1, rtype(6'h25, 1, 2, 3), 4, 1, 0);
    cycle();
    chk("beq_nt_next", {31'b0, ex_mem_valid}, 1);

    // Shadow ignores bubbles; squashed J never redirects
    drive(1, itype(6'h04, 1, 2, 16'h0004), 3, 3, 32'h20);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle();
    drive(1, rtype(6'h20, 1, 2, 3), 1, 1, 0);
    cycle();
    drive(0, 0, 0, 0, 0);
    cycle();
    drive(1, {6'h02, 26'h0000123}, 0, 0, 0);
    cycle();
    chk("sq_j_cond", {31'b0, ex_mem_cond}, 0);
    chk("sq_j_valid", {31'b0, ex_mem_valid}, 0);
    drive(1, rtype(6'h20, 1, 2, 3), 4, 4, 0);
    cycle();
    chk("after_shadow", ex_mem_alu_out, 8);

`ifdef FS_MUL_EN
    drive(1, rtype(6'h18, 1, 2, 4), 32'hFFFF_FFFF, 3, 0);
    n = 0; got_a = 0; got_rd = 0;
    do begin
      cycle();
      if (last_stall) n++;
      if (ex_mem_valid) begin got_a = ex_mem_alu_out; got_rd = ex_mem_rd; end
    end while (last_stall && n < 100);
    chk("mul_stall_cycles", n, 33);
    chk("mul_prod", got_a, 32'hFFFF_FFFD);
    chk("mul_rd", {27'b0, got_rd}, 4);
    drive(1, rtype(6'h18, 1, 2, 4), 7, 6, 0);
    repeat (10) cycle();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    cycle();
    reset = 1'b0;
    chk("rst_mul_stall", {31'b0, ex_stall}, 0);
    chk("rst_mul_valid", {31'b0, ex_mem_valid}, 0);
    repeat (40) cycle();
`else
    drive(1, rtype(6'h18, 1, 2, 4), 32'hFFFF_FFFF, 3, 0);
    cycle();
    chk("nomul_stall", {31'b0, last_stall}, 0);
    chk("nomul_dut_stall", {31'b0, ex_stall}, 0);
    chk("nomul_valid", {31'b0, ex_mem_valid}, 1);
    chk("nomul_rd", {27'b0, ex_mem_rd}, 0);
    chk("nomul_alu", ex_mem_alu_out, 0);
`endif

    last_stall = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (!last_stall) rand_instr();
      cycle();
    end
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
